// File: rtl/mem_pkg.sv
// Shared constants and FSM state encodings for the AXI4-Lite memory responder.
package mem_pkg;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;
    localparam logic [63:0] MEM_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_RESP = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_WAIT = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

endpackage

// File: rtl/mem_lat_cnt.sv
// Latency counter: loaded at a handshake, counts down to zero, flags zero.
module mem_lat_cnt #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/axi_lite_mem_resp.sv
// AXI4-Lite-style memory responder with fixed programmable read/write latency.
// Read and write paths are independent FSMs sharing one storage array.
module axi_lite_mem_resp
    import mem_pkg::*;
#(
    parameter int          DATA_W     = 64,
    parameter int          ADDR_W     = 64,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = MEM_BASE_ADDR,
    parameter int          RD_LAT     = 2,
    parameter int          WR_LAT     = 1
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iArValid,
    output logic                oArReady,
    input  logic [ADDR_W-1:0]   iArAddr,
    output logic                oRValid,
    input  logic                iRReady,
    output logic [DATA_W-1:0]   oRData,
    output logic [1:0]          oRResp,
    input  logic                iAwValid,
    output logic                oAwReady,
    input  logic [ADDR_W-1:0]   iAwAddr,
    input  logic                iWValid,
    output logic                oWReady,
    input  logic [DATA_W-1:0]   iWData,
    input  logic [DATA_W/8-1:0] iWStrb,
    output logic                oBValid,
    input  logic                iBReady,
    output logic [1:0]          oBResp
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int OFF_BITS = $clog2(STRB_W);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int RD_CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int WR_CW    = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam logic [ADDR_W-1:0] BASE    = BASE_ADDR[ADDR_W-1:0];
    localparam logic [RD_CW-1:0]  RD_INIT = RD_CW'(RD_LAT - 1);
    localparam logic [WR_CW-1:0]  WR_INIT = WR_CW'(WR_LAT - 1);

    // Returns {decerr, word_index}; byte-offset bits are dropped by the shift.
    function automatic logic [DEPTH_LOG2:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word;
        word = (addr - BASE) >> OFF_BITS;
        decode[DEPTH_LOG2-1:0] = word[DEPTH_LOG2-1:0];
        decode[DEPTH_LOG2]     = (addr < BASE) || ((word >> DEPTH_LOG2) != {ADDR_W{1'b0}});
    endfunction

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    rd_state_e          r_state_r, r_next_s;
    wr_state_e          w_state_r, w_next_s;
    logic               ar_ready_r, r_valid_r, aw_ready_r, b_valid_r;
    logic [DATA_W-1:0]  r_data_r;
    logic [1:0]         r_resp_r, b_resp_r;
    logic [ADDR_W-1:0]  ar_addr_r;
    logic               b_err_r;
    logic [DEPTH_LOG2:0] rd_dec_s, wr_dec_s;
    logic               ar_hs_s, w_hs_s, rd_zero_s, wr_zero_s;

    assign ar_hs_s  = ar_ready_r && iArValid && !iReset;
    assign w_hs_s   = aw_ready_r && iAwValid && iWValid && !iReset;
    assign rd_dec_s = decode(ar_addr_r);
    assign wr_dec_s = decode(iAwAddr);

    mem_lat_cnt #(.CNT_W(RD_CW)) u_rd_cnt (
        .clk      (iClock),
        .rst      (iReset),
        .load     (ar_hs_s),
        .load_val (RD_INIT),
        .dec      ((r_state_r == R_WAIT) && !rd_zero_s),
        .zero     (rd_zero_s)
    );

    mem_lat_cnt #(.CNT_W(WR_CW)) u_wr_cnt (
        .clk      (iClock),
        .rst      (iReset),
        .load     (w_hs_s),
        .load_val (WR_INIT),
        .dec      ((w_state_r == W_WAIT) && !wr_zero_s),
        .zero     (wr_zero_s)
    );

    // Read FSM next-state logic.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s)   r_next_s = R_WAIT; else r_next_s = R_IDLE;
            R_WAIT:  if (rd_zero_s) r_next_s = R_RESP; else r_next_s = R_WAIT;
            R_RESP:  if (iRReady)   r_next_s = R_IDLE; else r_next_s = R_RESP;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Write FSM next-state logic.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (w_hs_s)    w_next_s = W_WAIT; else w_next_s = W_IDLE;
            W_WAIT:  if (wr_zero_s) w_next_s = W_RESP; else w_next_s = W_WAIT;
            W_RESP:  if (iBReady)   w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // FSM state registers.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state_r <= R_IDLE;
            w_state_r <= W_IDLE;
        end else begin
            r_state_r <= r_next_s;
            w_state_r <= w_next_s;
        end
    end

    // Read channel registered outputs; data is sampled on entry to R_RESP.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_data_r   <= {DATA_W{1'b0}};
            r_resp_r   <= RESP_OKAY;
            ar_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            ar_ready_r <= (r_next_s == R_IDLE);
            r_valid_r  <= (r_next_s == R_RESP);
            if (ar_hs_s) begin
                ar_addr_r <= iArAddr;
            end else begin
                ar_addr_r <= ar_addr_r;
            end
            if ((r_state_r == R_WAIT) && rd_zero_s) begin
                r_data_r <= rd_dec_s[DEPTH_LOG2] ? {DATA_W{1'b0}} : mem[rd_dec_s[DEPTH_LOG2-1:0]];
                r_resp_r <= rd_dec_s[DEPTH_LOG2] ? RESP_DECERR : RESP_OKAY;
            end else begin
                r_data_r <= r_data_r;
                r_resp_r <= r_resp_r;
            end
        end
    end

    // Write channel registered outputs; decode result is captured at the handshake.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            aw_ready_r <= 1'b0;
            b_valid_r  <= 1'b0;
            b_resp_r   <= RESP_OKAY;
            b_err_r    <= 1'b0;
        end else begin
            aw_ready_r <= (w_next_s == W_IDLE);
            b_valid_r  <= (w_next_s == W_RESP);
            if (w_hs_s) begin
                b_err_r <= wr_dec_s[DEPTH_LOG2];
            end else begin
                b_err_r <= b_err_r;
            end
            if ((w_state_r == W_WAIT) && wr_zero_s) begin
                b_resp_r <= b_err_r ? RESP_DECERR : RESP_OKAY;
            end else begin
                b_resp_r <= b_resp_r;
            end
        end
    end

    // Storage: commit strobed bytes of an accepted in-range write on the handshake edge.
    always_ff @(posedge iClock) begin
        if (w_hs_s && !wr_dec_s[DEPTH_LOG2]) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (iWStrb[k]) begin
                    mem[wr_dec_s[DEPTH_LOG2-1:0]][k*8 +: 8] <= iWData[k*8 +: 8];
                end
            end
        end
    end

    assign oArReady = ar_ready_r;
    assign oRValid  = r_valid_r;
    assign oRData   = r_data_r;
    assign oRResp   = r_resp_r;
    assign oAwReady = aw_ready_r;
    assign oWReady  = aw_ready_r;
    assign oBValid  = b_valid_r;
    assign oBResp   = b_resp_r;

endmodule
